// File: rtl/rs_age_issue_queue_pkg.sv
// Shared types and sizing for the age-ordered reservation station.
package rs_age_issue_queue_pkg;

  localparam int unsigned NUM_ENTRIES = 16;
  localparam int unsigned NUM_FU      = 4;
  localparam int unsigned CDB_WIDTH   = 2;
  localparam int unsigned NUM_PR      = 64;
  localparam int unsigned TAG_W       = $clog2(NUM_PR);
  localparam int unsigned NUM_ROB     = 32;
  localparam int unsigned ROB_W       = $clog2(NUM_ROB);
  localparam int unsigned PAYLOAD_W   = 96;
  localparam int unsigned FU_TYPE_W   = 2;
  localparam int unsigned CNT_W       = $clog2(NUM_ENTRIES + 1);
  localparam int unsigned IDX_W       = $clog2(NUM_ENTRIES);

  typedef enum logic [FU_TYPE_W-1:0] {
    FuAlu    = 2'd0,
    FuMult   = 2'd1,
    FuMem    = 2'd2,
    FuBranch = 2'd3
  } FU_TYPE_t;

  // Issue port i serves FU_TYPE[i].
  localparam FU_TYPE_t FU_TYPE [NUM_FU] = '{FuAlu, FuMult, FuMem, FuBranch};

  typedef struct packed {
    logic             ready;
    logic [TAG_W-1:0] tag;
  } OPERAND_t;

  typedef struct packed {
    logic                 busy;
    FU_TYPE_t             fu_type;
    logic [TAG_W-1:0]     T;
    OPERAND_t             T1;
    OPERAND_t             T2;
    logic [ROB_W-1:0]     ROB_idx;
    logic [PAYLOAD_W-1:0] payload;
  } RS_ENTRY_t;

  localparam RS_ENTRY_t RS_ENTRY_RESET = '{
    busy: 1'b0, fu_type: FuAlu, T: '0, T1: '0, T2: '0, ROB_idx: '0, payload: '0
  };

  typedef struct packed {
    logic [ROB_W-1:0]     ROB_idx;
    logic [TAG_W-1:0]     T;
    logic [TAG_W-1:0]     T1_idx;
    logic [TAG_W-1:0]     T2_idx;
    logic [PAYLOAD_W-1:0] payload;
  } ISSUE_PKT_t;

  localparam int unsigned ISSUE_PKT_W = $bits(ISSUE_PKT_t);

  // Distance from origin to idx around the ROB ring.
  function automatic logic [ROB_W-1:0] rob_dist(input logic [ROB_W-1:0] idx,
                                                input logic [ROB_W-1:0] origin);
    rob_dist = idx - origin;
  endfunction

endpackage

// File: rtl/rs_age_issue_queue_select.sv
// Oldest-of-N picker: grants the requesting slot with the smallest age.
module rs_age_issue_queue_select #(
  parameter int unsigned N     = 16,
  parameter int unsigned AGE_W = 5
) (
  input  logic [N-1:0]            req_i,
  input  logic [N-1:0][AGE_W-1:0] age_i,
  output logic [N-1:0]            grant_o,
  output logic                    valid_o
);

  logic [AGE_W-1:0] best_age;
  logic             found;

  always_comb begin
    grant_o  = '0;
    found    = 1'b0;
    best_age = '1;
    for (int i = 0; i < N; i++) begin
      // ROB indices are unique, so strict compare never sees a tie.
      if (req_i[i] && (!found || (age_i[i] < best_age))) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        found      = 1'b1;
        best_age   = age_i[i];
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/rs_age_issue_queue.sv
// Shared reservation station: CDB wakeup, oldest-first issue per FU port, rollback squash.
module rs_age_issue_queue
  import rs_age_issue_queue_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            en,
  input  logic                            dispatch_en,
  input  logic [FU_TYPE_W-1:0]            dispatch_fu_type,
  input  logic [TAG_W:0]                  dispatch_T1,
  input  logic [TAG_W:0]                  dispatch_T2,
  input  logic [TAG_W-1:0]                dispatch_T,
  input  logic [ROB_W-1:0]                dispatch_ROB_idx,
  input  logic [PAYLOAD_W-1:0]            dispatch_payload,
  input  logic [ROB_W-1:0]                ROB_head_idx,
  input  logic [CDB_WIDTH-1:0]            CDB_valid,
  input  logic [CDB_WIDTH*TAG_W-1:0]      CDB_T_idx,
  input  logic [NUM_FU-1:0]               FU_ready,
  input  logic                            rollback_en,
  input  logic [ROB_W-1:0]                rollback_ROB_idx,
  input  logic [ROB_W-1:0]                rollback_depth,
  output logic                            RS_valid,
  output logic [CNT_W-1:0]                RS_count,
  output logic [NUM_FU-1:0]               issue_valid,
  output logic [NUM_FU*ISSUE_PKT_W-1:0]   issue_pkt
);

  RS_ENTRY_t entries_q [NUM_ENTRIES];
  RS_ENTRY_t entries_d [NUM_ENTRIES];
  logic [CNT_W-1:0] count_q, count_d;

  logic [NUM_ENTRIES-1:0]             t1_rdy, t2_rdy, squash, issued;
  logic [NUM_ENTRIES-1:0][ROB_W-1:0]  age;
  logic [NUM_FU-1:0][NUM_ENTRIES-1:0] req, grant;
  logic [IDX_W-1:0]                   free_idx;
  logic                               dispatch_fire;
  ISSUE_PKT_t                         pkt [NUM_FU];

  function automatic logic cdb_hit(input logic [TAG_W-1:0]           tag,
                                   input logic [CDB_WIDTH-1:0]       vld,
                                   input logic [CDB_WIDTH*TAG_W-1:0] tags);
    cdb_hit = 1'b0;
    for (int l = 0; l < CDB_WIDTH; l++) begin
      if (vld[l] && (tags[l*TAG_W +: TAG_W] == tag)) cdb_hit = 1'b1;
    end
  endfunction

  assign RS_valid = (count_q != CNT_W'(NUM_ENTRIES));
  assign RS_count = count_q;

  // Wakeup, age, squash and per-port requests.
  always_comb begin
    t1_rdy = '0;
    t2_rdy = '0;
    squash = '0;
    age    = '0;
    req    = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      t1_rdy[i] = entries_q[i].T1.ready || cdb_hit(entries_q[i].T1.tag, CDB_valid, CDB_T_idx);
      t2_rdy[i] = entries_q[i].T2.ready || cdb_hit(entries_q[i].T2.tag, CDB_valid, CDB_T_idx);
      age[i]    = rob_dist(entries_q[i].ROB_idx, ROB_head_idx);
      squash[i] = rollback_en && entries_q[i].busy &&
                  (rob_dist(entries_q[i].ROB_idx, rollback_ROB_idx) != '0) &&
                  (rob_dist(entries_q[i].ROB_idx, rollback_ROB_idx) <= rollback_depth);
      for (int p = 0; p < NUM_FU; p++) begin
        req[p][i] = entries_q[i].busy && (entries_q[i].fu_type == FU_TYPE[p]) &&
                    t1_rdy[i] && t2_rdy[i] && !squash[i];
      end
    end
  end

  for (genvar p = 0; p < NUM_FU; p++) begin : g_port
    rs_age_issue_queue_select #(
      .N     (NUM_ENTRIES),
      .AGE_W (ROB_W)
    ) u_select (
      .req_i   (req[p]),
      .age_i   (age),
      .grant_o (grant[p]),
      .valid_o (issue_valid[p])
    );
    assign issue_pkt[p*ISSUE_PKT_W +: ISSUE_PKT_W] = pkt[p];
  end

  // One-hot grant makes an OR-mux sufficient.
  always_comb begin
    for (int p = 0; p < NUM_FU; p++) begin
      pkt[p] = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (grant[p][i]) begin
          pkt[p] = pkt[p] | ISSUE_PKT_t'{
            ROB_idx: entries_q[i].ROB_idx,
            T:       entries_q[i].T,
            T1_idx:  entries_q[i].T1.tag,
            T2_idx:  entries_q[i].T2.tag,
            payload: entries_q[i].payload
          };
        end
      end
    end
  end

  always_comb begin
    issued = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int p = 0; p < NUM_FU; p++) begin
        if (grant[p][i] && FU_ready[p]) issued[i] = 1'b1;
      end
    end
  end

  always_comb begin
    logic found;
    found    = 1'b0;
    free_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!entries_q[i].busy && !found) begin
        found    = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign dispatch_fire = en && dispatch_en && RS_valid && !rollback_en;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) entries_d[i] = entries_q[i];
    if (en) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (squash[i] || issued[i]) begin
          entries_d[i] = RS_ENTRY_RESET;
        end else if (entries_q[i].busy) begin
          entries_d[i].T1.ready = t1_rdy[i];
          entries_d[i].T2.ready = t2_rdy[i];
        end
      end
      if (dispatch_fire) begin
        entries_d[free_idx].busy     = 1'b1;
        entries_d[free_idx].fu_type  = FU_TYPE_t'(dispatch_fu_type);
        entries_d[free_idx].T        = dispatch_T;
        entries_d[free_idx].T1.tag   = dispatch_T1[TAG_W-1:0];
        entries_d[free_idx].T1.ready = dispatch_T1[TAG_W] ||
                                       cdb_hit(dispatch_T1[TAG_W-1:0], CDB_valid, CDB_T_idx);
        entries_d[free_idx].T2.tag   = dispatch_T2[TAG_W-1:0];
        entries_d[free_idx].T2.ready = dispatch_T2[TAG_W] ||
                                       cdb_hit(dispatch_T2[TAG_W-1:0], CDB_valid, CDB_T_idx);
        entries_d[free_idx].ROB_idx  = dispatch_ROB_idx;
        entries_d[free_idx].payload  = dispatch_payload;
      end
    end
    count_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (entries_d[i].busy) count_d = count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= RS_ENTRY_RESET;
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= entries_d[i];
      count_q <= count_d;
    end
  end

  a_dispatch_when_full : assert property (@(posedge clock) disable iff (!reset)
    (en && dispatch_en && !rollback_en) |-> RS_valid)
    else $warning("dispatch_en with RS full, request dropped");

endmodule
